// File: rtl/mux_cl_seq_if.sv
// Bus bundle for the mux_cl_seq channel selector: parallel channel inputs,
// transfer control and the valid/ready output port.
interface mux_cl_seq_if #(
    parameter int NCH  = 8,
    parameter int W    = 1,
    parameter int SELW = 3
);
    logic [NCH*W-1:0] din;
    logic             req;
    logic             mode;
    logic [SELW-1:0]  sel;
    logic             abort;
    logic             out_ready;
    logic             out_valid;
    logic [W-1:0]     dout;
    logic [SELW-1:0]  dout_ch;
    logic             busy;
    logic             scan_done;

    modport slave (
        input  din, req, mode, sel, abort, out_ready,
        output out_valid, dout, dout_ch, busy, scan_done
    );

    modport master (
        output din, req, mode, sel, abort, out_ready,
        input  out_valid, dout, dout_ch, busy, scan_done
    );
endinterface

// File: rtl/mux_cl_seq.sv
// Registered N:1 channel selector: serves one addressed channel (direct) or
// all channels in order (scan) on a valid/ready port held under back-pressure.
module mux_cl_seq #(
    parameter int NCH  = 8,
    parameter int W    = 1,
    parameter int SELW = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    mux_cl_seq_if.slave bus
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_SHOW = 1'b1
    } state_t;

    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    // Indices at or beyond NCH (non power-of-two NCH) select an all-zero word.
    function automatic logic [W-1:0] pick_ch(input logic [NCH*W-1:0] data,
                                             input logic [SELW-1:0]  idx);
        logic [W-1:0] res;
        res = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx == SELW'(k)) begin
                res = data[k*W +: W];
            end
        end
        return res;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_m;
    logic [SELW-1:0] r_ch_p1;
    logic [W-1:0]    r_dout_p1;
    logic            r_vld_p1;
    logic            r_done_p1;

    logic            w_start;
    logic            w_abort;
    logic            w_accept;
    logic            w_adv;
    logic [SELW-1:0] w_start_ch;
    logic [SELW-1:0] w_next_ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    w_state_nxt = S_SHOW;
                end
            end
            S_SHOW: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.out_ready && (!r_m || (r_ch_p1 == LAST_CH))) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control strobes; abort wins over out_ready, last scan word ends the transfer.
    always_comb begin
        w_start    = 1'b0;
        w_abort    = 1'b0;
        w_accept   = 1'b0;
        w_adv      = 1'b0;
        w_start_ch = bus.mode ? '0 : bus.sel;
        w_next_ch  = r_ch_p1 + SELW'(1);
        case (r_state)
            S_IDLE: begin
                w_start = bus.req;
            end
            S_SHOW: begin
                w_abort  = bus.abort;
                w_accept = !bus.abort && bus.out_ready;
                w_adv    = w_accept && r_m && (r_ch_p1 != LAST_CH);
            end
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    // p1: registered output word, channel index, valid and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m       <= 1'b0;
            r_ch_p1   <= '0;
            r_dout_p1 <= '0;
            r_vld_p1  <= 1'b0;
            r_done_p1 <= 1'b0;
        end else begin
            r_done_p1 <= 1'b0;
            if (w_start) begin
                r_m       <= bus.mode;
                r_ch_p1   <= w_start_ch;
                r_dout_p1 <= pick_ch(bus.din, w_start_ch);
                r_vld_p1  <= 1'b1;
            end else if (w_abort) begin
                r_vld_p1  <= 1'b0;
            end else if (w_adv) begin
                r_ch_p1   <= w_next_ch;
                r_dout_p1 <= pick_ch(bus.din, w_next_ch);
            end else if (w_accept) begin
                r_vld_p1  <= 1'b0;
                r_done_p1 <= r_m;
            end
        end
    end

    assign bus.out_valid = r_vld_p1;
    assign bus.dout      = r_dout_p1;
    assign bus.dout_ch   = r_ch_p1;
    assign bus.scan_done = r_done_p1;
    assign bus.busy      = (r_state == S_SHOW);
endmodule

// File: tb/tb_mux_cl_seq.sv
// Scoreboard bench for mux_cl_seq: directed transfers push expected words,
// negedge monitors pop and compare every accepted word.
module tb_mux_cl_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_cl_seq_if #(.NCH(8), .W(4), .SELW(3)) b8();
    mux_cl_seq_if #(.NCH(6), .W(4), .SELW(3)) b6();

    mux_cl_seq #(.NCH(8), .W(4), .SELW(3)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    mux_cl_seq #(.NCH(6), .W(4), .SELW(3)) u_dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));

    typedef struct packed {
        logic [3:0] d;
        logic [2:0] ch;
    } exp_t;

    exp_t q8[$];
    exp_t q6[$];
    exp_t e8;
    exp_t e6;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && b8.out_valid && b8.out_ready && !b8.abort) begin
            if (q8.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL mon8_extra: got ch %0d data %0h expected no word", b8.dout_ch, b8.dout);
            end else begin
                e8 = q8.pop_front();
                chk("mon8_dout", 32'(b8.dout), 32'(e8.d));
                chk("mon8_ch", 32'(b8.dout_ch), 32'(e8.ch));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b6.out_valid && b6.out_ready && !b6.abort) begin
            if (q6.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL mon6_extra: got ch %0d data %0h expected no word", b6.dout_ch, b6.dout);
            end else begin
                e6 = q6.pop_front();
                chk("mon6_dout", 32'(b6.dout), 32'(e6.d));
                chk("mon6_ch", 32'(b6.dout_ch), 32'(e6.ch));
            end
        end
    end

    initial begin
        b8.din = '0; b8.req = 0; b8.mode = 0; b8.sel = '0; b8.abort = 0; b8.out_ready = 0;
        b6.din = '0; b6.req = 0; b6.mode = 0; b6.sel = '0; b6.abort = 0; b6.out_ready = 0;
        rst_n = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(b8.out_valid), 0);
        chk("rst_dout", 32'(b8.dout), 0);
        chk("rst_ch", 32'(b8.dout_ch), 0);
        chk("rst_busy", 32'(b8.busy), 0);
        chk("rst_done", 32'(b8.scan_done), 0);
        rst_n = 1'b1;
        step();

        // Direct mode with back-pressure; source changes while held
        b8.din[5*4 +: 4] = 4'hA;
        b8.sel = 3'd5; b8.mode = 1'b0; b8.req = 1'b1; b8.out_ready = 1'b0;
        q8.push_back({4'hA, 3'd5});
        step();
        b8.req = 1'b0;
        b8.din[5*4 +: 4] = 4'h3;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(b8.out_valid), 1);
            chk("bp_dout", 32'(b8.dout), 32'hA);
            chk("bp_ch", 32'(b8.dout_ch), 5);
            step();
        end
        b8.out_ready = 1'b1;
        step();
        b8.out_ready = 1'b0;
        chk("bp_valid_after", 32'(b8.out_valid), 0);
        chk("bp_done_after", 32'(b8.scan_done), 0);
        step();

        // Full scan, out_ready always high
        for (int k = 0; k < 8; k++) begin
            b8.din[k*4 +: 4] = 4'(k);
            q8.push_back({4'(k), 3'(k)});
        end
        b8.mode = 1'b1; b8.req = 1'b1; b8.out_ready = 1'b1;
        step();
        b8.req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("scan_valid", 32'(b8.out_valid), 1);
            chk("scan_dout", 32'(b8.dout), 32'(k));
            chk("scan_ch", 32'(b8.dout_ch), 32'(k));
            chk("scan_done_early", 32'(b8.scan_done), 0);
            step();
        end
        chk("scan_done_pulse", 32'(b8.scan_done), 1);
        chk("scan_done_busy", 32'(b8.busy), 0);
        chk("scan_done_valid", 32'(b8.out_valid), 0);
        b8.out_ready = 1'b0;
        step();
        chk("scan_done_one_cycle", 32'(b8.scan_done), 0);

        // Scan under toggling back-pressure with ignored req pulses
        for (int k = 0; k < 8; k++) begin
            b8.din[k*4 +: 4] = 4'(15 - k);
            q8.push_back({4'(15 - k), 3'(k)});
        end
        b8.mode = 1'b1; b8.req = 1'b1; b8.out_ready = 1'b0;
        step();
        b8.req = 1'b0;
        done4 = 1'b0;
        for (int c = 0; c < 60 && !done4; c++) begin
            b8.out_ready = (c % 3 == 0);
            b8.req = (c == 5 || c == 11);
            b8.mode = 1'b0;
            b8.sel = 3'd2;
            step();
            if (b8.scan_done) done4 = 1'b1;
        end
        b8.req = 1'b0;
        b8.out_ready = 1'b0;
        chk("bp_scan_done_seen", 32'(done4), 1);
        chk("bp_scan_queue_empty", 32'(q8.size()), 0);
        step();
        chk("bp_scan_no_queued_req", 32'(b8.busy), 0);
        chk("bp_scan_idle_valid", 32'(b8.out_valid), 0);

        // Abort at ch3 with out_ready high, then immediate new request
        for (int k = 0; k < 8; k++) begin
            b8.din[k*4 +: 4] = 4'(k + 1);
        end
        q8.push_back({4'd1, 3'd0});
        q8.push_back({4'd2, 3'd1});
        q8.push_back({4'd3, 3'd2});
        b8.mode = 1'b1; b8.req = 1'b1; b8.out_ready = 1'b1;
        step();
        b8.req = 1'b0;
        step();
        step();
        step();
        chk("abort_at_ch", 32'(b8.dout_ch), 3);
        b8.abort = 1'b1;
        step();
        b8.abort = 1'b0;
        chk("abort_valid", 32'(b8.out_valid), 0);
        chk("abort_busy", 32'(b8.busy), 0);
        chk("abort_done", 32'(b8.scan_done), 0);
        b8.req = 1'b1; b8.mode = 1'b0; b8.sel = 3'd6; b8.out_ready = 1'b0;
        q8.push_back({4'd7, 3'd6});
        step();
        b8.req = 1'b0;
        chk("abort_done_stays", 32'(b8.scan_done), 0);
        chk("post_abort_valid", 32'(b8.out_valid), 1);
        chk("post_abort_ch", 32'(b8.dout_ch), 6);
        chk("post_abort_dout", 32'(b8.dout), 7);
        b8.out_ready = 1'b1;
        step();
        b8.out_ready = 1'b0;
        chk("post_abort_accepted", 32'(b8.out_valid), 0);

        // NCH=6: out-of-range select gives zero data, in-range gives channel data
        for (int k = 0; k < 6; k++) begin
            b6.din[k*4 +: 4] = 4'(k + 9);
        end
        q6.push_back({4'h0, 3'd7});
        b6.mode = 1'b0; b6.sel = 3'd7; b6.req = 1'b1; b6.out_ready = 1'b0;
        step();
        b6.req = 1'b0;
        chk("n6_oor_valid", 32'(b6.out_valid), 1);
        chk("n6_oor_dout", 32'(b6.dout), 0);
        chk("n6_oor_ch", 32'(b6.dout_ch), 7);
        b6.out_ready = 1'b1;
        step();
        b6.out_ready = 1'b0;
        chk("n6_oor_accepted", 32'(b6.out_valid), 0);
        chk("n6_oor_done", 32'(b6.scan_done), 0);
        q6.push_back({4'hE, 3'd5});
        b6.sel = 3'd5; b6.req = 1'b1;
        step();
        b6.req = 1'b0;
        chk("n6_ch5_dout", 32'(b6.dout), 32'hE);
        chk("n6_ch5_ch", 32'(b6.dout_ch), 5);
        b6.out_ready = 1'b1;
        step();
        b6.out_ready = 1'b0;
        chk("n6_ch5_accepted", 32'(b6.out_valid), 0);

        // Asynchronous reset mid-scan at ch3, then scan restarts at ch0
        for (int k = 0; k < 8; k++) begin
            b8.din[k*4 +: 4] = 4'(k);
        end
        q8.push_back({4'd0, 3'd0});
        q8.push_back({4'd1, 3'd1});
        q8.push_back({4'd2, 3'd2});
        b8.mode = 1'b1; b8.req = 1'b1; b8.out_ready = 1'b1;
        step();
        b8.req = 1'b0;
        step();
        step();
        step();
        chk("mid_rst_ch_before", 32'(b8.dout_ch), 3);
        b8.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(b8.out_valid), 0);
        chk("mid_rst_dout", 32'(b8.dout), 0);
        chk("mid_rst_ch", 32'(b8.dout_ch), 0);
        chk("mid_rst_busy", 32'(b8.busy), 0);
        chk("mid_rst_done", 32'(b8.scan_done), 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            q8.push_back({4'(k), 3'(k)});
        end
        b8.mode = 1'b1; b8.req = 1'b1; b8.out_ready = 1'b1;
        step();
        b8.req = 1'b0;
        chk("restart_ch", 32'(b8.dout_ch), 0);
        chk("restart_dout", 32'(b8.dout), 0);
        chk("restart_valid", 32'(b8.out_valid), 1);
        repeat (8) step();
        b8.out_ready = 1'b0;
        chk("restart_done", 32'(b8.scan_done), 1);

        step();
        step();
        chk("final_q8_empty", 32'(q8.size()), 0);
        chk("final_q6_empty", 32'(q6.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
